inv_reg_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared conditional-invert register. The register computes `result = bit2 ? ~bit : bit`, one transaction at a time. The block accepts requests from up to NREQ clients, grants one client, and latches that client's operand and invert select. It then drives the registered result back under a valid/acknowledge handshake, with a timeout that frees the resource and flags an error.

---
 rtl/inv_reg_arbiter_pkg.sv | 9 +
 rtl/inv_reg_arbiter_rr_pick.sv | 30 +++
 rtl/inv_reg_arbiter.sv | 113 +++++++++++
 tb/tb_inv_reg_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/inv_reg_arbiter_pkg.sv
// inv_reg_arbiter_pkg: shared FSM encodings and sizing helpers for the conditional-invert register arbiter.
package inv_reg_arbiter_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   function automatic int cnt_w(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction
endpackage

// File: rtl/inv_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr_i wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);
   int j;
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j = 0;
      // scan farthest to nearest so the closest requester overwrites last
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = int'(ptr_i) + i;
         j = (j >= NREQ) ? j - NREQ : j;
         if (req_i[j]) begin
            gnt_o = '0;
            gnt_o[j] = 1'b1;
            idx_o = PW'(j);
            any_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/inv_reg_arbiter.sv
// inv_reg_arbiter: round-robin arbiter and sequencer for the shared conditional-invert register,
// with valid/ack response handshake, timeout abort and sticky error.
module inv_reg_arbiter
   import inv_reg_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int WIDTH = 1,
   parameter int TIMEOUT = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*WIDTH-1:0] DIN,
   input  logic [NREQ-1:0]       INV,
   input  logic                  ACK,
   input  logic                  ERR_CLR,
   output logic [NREQ-1:0]       GNT,
   output logic [WIDTH-1:0]      DOUT,
   output logic                  DVALID,
   output logic                  BUSY,
   output logic                  ERR
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = cnt_w(TIMEOUT);
   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d, idx_q, idx_d, ptr_next;
   logic [WIDTH-1:0] din_q, din_d, dout_q, dout_d;
   logic             inv_q, inv_d, dvalid_q, dvalid_d, err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d, pick_gnt;
   logic [PW-1:0]    pick_idx;
   logic             pick_any, done;
   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req_i(REQ),
      .ptr_i(ptr_q),
      .gnt_o(pick_gnt),
      .idx_o(pick_idx),
      .any_o(pick_any)
   );
   assign ptr_next = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
   assign done = ACK || (cnt_q == CW'(TIMEOUT - 1));
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      idx_d = idx_q;
      din_d = din_q;
      inv_d = inv_q;
      cnt_d = cnt_q;
      dout_d = dout_q;
      dvalid_d = dvalid_q;
      gnt_d = gnt_q;
      err_d = err_q & ~ERR_CLR;
      case (state_q)
         ST_IDLE: if (pick_any) begin
            state_d = ST_EXEC;
            idx_d = pick_idx;
            din_d = DIN[pick_idx*WIDTH +: WIDTH];
            inv_d = INV[pick_idx];
            gnt_d = pick_gnt;
         end
         ST_EXEC: begin
            dout_d = inv_q ? ~din_q : din_q;
            cnt_d = '0;
            dvalid_d = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: if (done) begin
            dvalid_d = 1'b0;
            gnt_d = '0;
            ptr_d = ptr_next;
            state_d = ST_IDLE;
            err_d = ACK ? err_d : 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d = '0;
            dvalid_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ptr_q <= '0;
         idx_q <= '0;
         din_q <= '0;
         inv_q <= 1'b0;
         cnt_q <= '0;
         dout_q <= '0;
         dvalid_q <= 1'b0;
         gnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         idx_q <= idx_d;
         din_q <= din_d;
         inv_q <= inv_d;
         cnt_q <= cnt_d;
         dout_q <= dout_d;
         dvalid_q <= dvalid_d;
         gnt_q <= gnt_d;
         err_q <= err_d;
      end
   end
   assign GNT = gnt_q;
   assign DOUT = dout_q;
   assign DVALID = dvalid_q;
   assign BUSY = (state_q != ST_IDLE);
   assign ERR = err_q;
endmodule

// File: tb/tb_inv_reg_arbiter.sv
// tb_inv_reg_arbiter: directed scoreboard bench for the round-robin conditional-invert arbiter.
module tb_inv_reg_arbiter;
   logic CLK = 1'b0;
   logic RST, ACK, ERR_CLR, DOUT, DVALID, BUSY, ERR;
   logic [3:0] REQ, DIN, INV, GNT;
   int compared = 0;
   int mismatched = 0;
   typedef struct {logic [3:0] gnt; logic dout;} exp_t;
   exp_t sb[$];
   inv_reg_arbiter #(.NREQ(4), .WIDTH(1), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN), .INV(INV), .ACK(ACK), .ERR_CLR(ERR_CLR),
      .GNT(GNT), .DOUT(DOUT), .DVALID(DVALID), .BUSY(BUSY), .ERR(ERR)
   );
   always #5 CLK = ~CLK;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic grant_step(input logic [3:0] req, input logic [3:0] din, input logic [3:0] inv,
                             input logic [3:0] egnt, input logic edout);
      REQ = req;
      DIN = din;
      INV = inv;
      sb.push_back('{egnt, edout});
      tick();
      chk("grant", GNT, egnt);
      chk("busy_exec", BUSY, 1);
      chk("dvalid_exec", DVALID, 0);
   endtask
   task automatic exec_step();
      exp_t e;
      tick();
      chk("dvalid_resp", DVALID, 1);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("resp_gnt", GNT, e.gnt);
         chk("resp_dout", DOUT, e.dout);
      end
   endtask
   task automatic ack_step();
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      chk("ack_gnt", GNT, 0);
      chk("ack_dvalid", DVALID, 0);
      chk("ack_busy", BUSY, 0);
   endtask
   task automatic txn(input logic [3:0] req, input logic [3:0] din, input logic [3:0] inv,
                      input logic [3:0] egnt, input logic edout);
      grant_step(req, din, inv, egnt, edout);
      exec_step();
      ack_step();
   endtask
   task automatic timeout_run(input logic [3:0] egnt, input logic edout, input logic clr_held);
      int n;
      grant_step(egnt, 4'b0100, 4'b0000, egnt, edout);
      REQ = 4'b0000;
      ERR_CLR = clr_held;
      exec_step();
      n = 1;
      while (DVALID && n < 40) begin
         chk("hold_gnt", GNT, egnt);
         tick();
         n += DVALID ? 1 : 0;
      end
      chk("dvalid_cycles", n, 16);
      chk("to_err", ERR, 1);
      chk("to_gnt", GNT, 0);
      chk("to_busy", BUSY, 0);
   endtask
   initial begin
      RST = 1'b1; ACK = 1'b0; ERR_CLR = 1'b0; REQ = '0; DIN = '0; INV = '0;
      tick(); tick();
      RST = 1'b0;
      chk("rst_gnt", GNT, 0);
      chk("rst_dout", DOUT, 0);
      chk("rst_dvalid", DVALID, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_err", ERR, 0);
      txn(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0);
      txn(4'b0011, 4'b0011, 4'b0000, 4'b0010, 1'b1);
      RST = 1'b1; REQ = '0; tick(); RST = 1'b0;
      txn(4'b1111, 4'b1010, 4'b0110, 4'b0001, 1'b0);
      txn(4'b1111, 4'b1010, 4'b0110, 4'b0010, 1'b0);
      txn(4'b1111, 4'b1010, 4'b0110, 4'b0100, 1'b1);
      txn(4'b1111, 4'b1010, 4'b0110, 4'b1000, 1'b1);
      txn(4'b1111, 4'b1010, 4'b0110, 4'b0001, 1'b0);
      txn(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0);
      txn(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1);
      txn(4'b1001, 4'b1000, 4'b0000, 4'b1000, 1'b1);
      txn(4'b1001, 4'b0000, 4'b0001, 4'b0001, 1'b1);
      REQ = '0;
      timeout_run(4'b0100, 1'b1, 1'b0);
      tick();
      chk("err_sticky", ERR, 1);
      ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
      chk("err_clr", ERR, 0);
      timeout_run(4'b1000, 1'b0, 1'b1);
      tick();
      ERR_CLR = 1'b0;
      chk("err_clr_after_set", ERR, 0);
      grant_step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
      exec_step();
      RST = 1'b1; tick(); RST = 1'b0; REQ = '0;
      chk("mid_rst_gnt", GNT, 0);
      chk("mid_rst_dout", DOUT, 0);
      chk("mid_rst_dvalid", DVALID, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_err", ERR, 0);
      ACK = 1'b1; tick();
      chk("idle_ack_busy", BUSY, 0);
      REQ = 4'b0010; DIN = 4'b0010; INV = 4'b0000;
      sb.push_back('{4'b0010, 1'b1});
      tick();
      chk("ack_idle_grant", GNT, 4'b0010);
      exec_step();
      ack_step();
      grant_step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1);
      REQ = 4'b0000; DIN = 4'b0000; INV = 4'b1111;
      exec_step();
      tick(); tick();
      chk("late_gnt", GNT, 4'b0100);
      chk("late_dout", DOUT, 1);
      ack_step();
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
